// File: rtl/logic_bist_pkg.sv
// logic_bist_pkg: shared FSM states, logic-unit opcodes and the golden truth table
package logic_bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        DONE
    } state_t;

    localparam logic [2:0] OP_NOT   = 3'd0;
    localparam logic [2:0] OP_NOR   = 3'd1;
    localparam logic [2:0] OP_AND   = 3'd2;
    localparam logic [2:0] OP_OR    = 3'd3;
    localparam logic [2:0] OP_XOR   = 3'd4;
    localparam logic [2:0] OP_XNOR  = 3'd5;
    localparam logic [2:0] OP_NAND  = 3'd6;
    localparam logic [2:0] OP_NAND2 = 3'd7;

    localparam logic [31:0] EXP_TT  = 32'h7796E813;
    localparam logic [4:0]  LAST_IDX = 5'd31;
    localparam logic [5:0]  ERR_MAX  = 6'd63;

endpackage

// File: rtl/logic_bist_sequencer_golden.sv
// logic_golden: combinational reference result of the logic unit for one opcode/operand set
module logic_golden
    import logic_bist_pkg::*;
(
    input  logic [2:0] sel,
    input  logic       a,
    input  logic       b,
    output logic       exp
);

    // opcode decode into the expected logic-unit result
    always_comb
        exp = (sel == OP_NOT)  ? ~a       :
              (sel == OP_NOR)  ? ~(a | b) :
              (sel == OP_AND)  ?  (a & b) :
              (sel == OP_OR)   ?  (a | b) :
              (sel == OP_XOR)  ?  (a ^ b) :
              (sel == OP_XNOR) ? ~(a ^ b) :
                                 ~(a & b);

endmodule

// File: rtl/logic_bist_sequencer.sv
// logic_bist_sequencer: sweeps all 32 logic-unit vectors and checks them; LOGIC_BIST_ERRCNT_EN enables full-sweep error counting
module logic_bist_sequencer
    import logic_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        lu_a,
    output logic        lu_b,
    output logic [2:0]  lu_sel,
    input  logic        lu_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  fail_idx,
    output logic [5:0]  err_count,
    output logic [31:0] tt_capture
);

    localparam logic [2:0] HOLD = 3'(SETTLE_CYCLES);
`ifdef LOGIC_BIST_ERRCNT_EN
    localparam bit STOP_ON_FAIL = 1'b0;
`else
    localparam bit STOP_ON_FAIL = 1'b1;
`endif

    state_t     state;
    logic [4:0] idx;
    logic [2:0] cnt;
    logic       exp;
    logic       miss;
    logic       sample;
    logic       last;
    logic       launch;

    assign {lu_sel, lu_a, lu_b} = idx;

    logic_golden u_golden (
        .sel (lu_sel),
        .a   (lu_a),
        .b   (lu_b),
        .exp (exp)
    );

    assign miss   = lu_out != exp;
    assign sample = (state == APPLY) && (cnt == HOLD);
    assign last   = (idx == LAST_IDX) || (STOP_ON_FAIL && miss);
    assign launch = start && (state != APPLY);

    // run control: hold each vector for the settle window, capture, compare, advance or finish
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_idx   <= '0;
            tt_capture <= '0;
        end else begin
            case (state)
                IDLE, DONE:
                    if (start) begin
                        state      <= APPLY;
                        idx        <= '0;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b1;
                        fail_idx   <= '0;
                        tt_capture <= '0;
                    end
                APPLY:
                    if (!sample)
                        cnt <= cnt + 3'd1;
                    else begin
                        cnt             <= '0;
                        tt_capture[idx] <= lu_out;
                        if (miss) begin
                            pass <= 1'b0;
                            if (pass)
                                fail_idx <= idx;
                        end
                        if (last) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else
                            idx <= idx + 5'd1;
                    end
                default:
                    state <= IDLE;
            endcase
        end

`ifdef LOGIC_BIST_ERRCNT_EN
    logic [5:0] err_cnt;

    // mismatch count over the full sweep, saturating at the top of its range
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            err_cnt <= '0;
        else if (launch)
            err_cnt <= '0;
        else if (sample && miss && (err_cnt != ERR_MAX))
            err_cnt <= err_cnt + 6'd1;

    assign err_count = err_cnt;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_logic_bist_sequencer.sv
// tb_logic_bist_sequencer: randomized self-checking bench against a truth-table level run model
module tb_logic_bist_sequencer;

    localparam int S  = 1;
    localparam int S3 = 3;
`ifdef LOGIC_BIST_ERRCNT_EN
    localparam bit ERRCNT = 1'b1;
`else
    localparam bit ERRCNT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        start3 = 1'b0;
    logic        lu_a, lu_b, lu_out, busy, done, pass;
    logic [2:0]  lu_sel;
    logic [4:0]  fail_idx;
    logic [5:0]  err_count;
    logic [31:0] tt_capture;
    logic        lu_a3, lu_b3, lu_out3, busy3, done3, pass3;
    logic [2:0]  lu_sel3;
    logic [4:0]  fail_idx3;
    logic [5:0]  err_count3;
    logic [31:0] tt_capture3;
    logic [31:0] unit = '0;
    logic [31:0] ref_tt = '0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign lu_out  = unit[{lu_sel, lu_a, lu_b}];
    assign lu_out3 = ref_tt[{lu_sel3, lu_a3, lu_b3}];

    logic_bist_sequencer #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .lu_a(lu_a), .lu_b(lu_b), .lu_sel(lu_sel), .lu_out(lu_out),
        .busy(busy), .done(done), .pass(pass),
        .fail_idx(fail_idx), .err_count(err_count), .tt_capture(tt_capture)
    );

    logic_bist_sequencer #(.SETTLE_CYCLES(S3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3),
        .lu_a(lu_a3), .lu_b(lu_b3), .lu_sel(lu_sel3), .lu_out(lu_out3),
        .busy(busy3), .done(done3), .pass(pass3),
        .fail_idx(fail_idx3), .err_count(err_count3), .tt_capture(tt_capture3)
    );

    function automatic logic ref_bit(input int i);
        logic a, b;
        a = (i / 2) % 2 == 1;
        b = i % 2 == 1;
        case (i / 4)
            0:       return !a;
            1:       return !(a || b);
            2:       return a && b;
            3:       return a || b;
            4:       return a != b;
            5:       return a == b;
            default: return !(a && b);
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    bit          m_active = 1'b0;
    int          mk, m_d, m_last, m_f, m_err;
    logic [31:0] m_unit, m_diff;

    always @(posedge clk or negedge rst_n)
        if (!rst_n)
            m_active = 1'b0;
        else if (start && !(m_active && mk < m_d)) begin
            m_active = 1'b1;
            mk       = 0;
            m_unit   = unit;
            m_diff   = unit ^ ref_tt;
            m_f      = 0;
            for (int i = 31; i >= 0; i--)
                if (m_diff[i])
                    m_f = i;
            m_err  = $countones(m_diff);
            m_last = (!ERRCNT && m_diff != 0) ? m_f : 31;
            m_d    = (m_last + 1) * (S + 1);
        end else if (m_active && mk < 1000)
            mk++;

    int          cn, cv;
    logic [63:0] cmask;

    always @(negedge clk)
        if (!rst_n || !m_active)
            chk("idle_outputs", {busy, done, pass, fail_idx, err_count, lu_sel, lu_a, lu_b, tt_capture}, 64'd0);
        else begin
            cn    = (mk / (S + 1) < m_last + 1) ? mk / (S + 1) : m_last + 1;
            cv    = (mk / (S + 1) < m_last) ? mk / (S + 1) : m_last;
            cmask = (64'd1 << cn) - 64'd1;
            chk("busy", busy, mk < m_d);
            chk("done", done, mk >= m_d);
            chk("vector", {lu_sel, lu_a, lu_b}, cv);
            chk("tt_capture", tt_capture, m_unit & cmask[31:0]);
            if (mk >= m_d) begin
                chk("pass", pass, m_diff == 0);
                chk("fail_idx", fail_idx, (m_diff == 0) ? 0 : m_f);
                chk("err_count", err_count, ERRCNT ? m_err : 0);
            end
        end

    task automatic run(input logic [31:0] u, input int poke, output int cyc);
        unit  = u;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (cyc < 300) begin
            cyc++;
            start = (cyc == poke);
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            if (done)
                break;
        end
    endtask

    initial begin
        int          cyc, ef;
        logic [31:0] m, u;
        for (int i = 0; i < 32; i++)
            ref_tt[i] = ref_bit(i);
        unit = ref_tt;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("reset_state", {busy, done, pass, fail_idx, err_count, tt_capture, busy3, done3}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run(ref_tt, 10, cyc);
        chk("clean_done_cycle", cyc, 64);
        chk("clean_pass", pass, 1);
        chk("clean_tt", tt_capture, 32'h7796E813);
        chk("clean_err", err_count, 0);

        run(32'h0, 0, cyc);
        chk("stuck0_done_cycle", cyc, ERRCNT ? 64 : 2);
        chk("stuck0_pass", pass, 0);
        chk("stuck0_fail_idx", fail_idx, 0);
        chk("stuck0_err", err_count, ERRCNT ? 17 : 0);
        chk("stuck0_tt", tt_capture, 0);

        u = ref_tt;
        u[31:28] = 4'b1000;
        run(u, 0, cyc);
        chk("op7and_done_cycle", cyc, ERRCNT ? 64 : 58);
        chk("op7and_pass", pass, 0);
        chk("op7and_fail_idx", fail_idx, 28);
        chk("op7and_err", err_count, ERRCNT ? 4 : 0);

        unit  = ref_tt;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("midrun_reset", {busy, done, pass, fail_idx, err_count, lu_sel, lu_a, lu_b, tt_capture}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(ref_tt, 0, cyc);
        chk("after_reset_done_cycle", cyc, 64);
        chk("after_reset_pass", pass, 1);
        chk("after_reset_tt", tt_capture, 32'h7796E813);

        repeat (25) begin
            case ($urandom_range(0, 3))
                0:       m = 32'h0;
                1:       m = 32'd1 << $urandom_range(0, 31);
                2:       m = $urandom & $urandom & $urandom;
                default: m = $urandom;
            endcase
            run(ref_tt ^ m, $urandom_range(0, 70), cyc);
            ef = 31;
            for (int i = 31; i >= 0; i--)
                if (m[i])
                    ef = i;
            chk("random_done_cycle", cyc, (!ERRCNT && m != 0) ? (ef + 1) * (S + 1) : 32 * (S + 1));
        end

        start3 = 1'b1;
        @(posedge clk);
        #1 start3 = 1'b0;
        cyc = 0;
        while (cyc < 400) begin
            cyc++;
            @(posedge clk);
            @(negedge clk);
            if (done3)
                break;
        end
        chk("settle3_done_cycle", cyc, 128);
        chk("settle3_pass", pass3, 1);
        chk("settle3_tt", tt_capture3, 32'h7796E813);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_bist_sequencer.md
LOGIC_BIST_SEQUENCER -- requirements
Module: logic_bist_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, giving extra hold cycles per vector before lu_out is sampled (legal range 0..7).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, single-cycle run request.
REQ-005 SHALL have ports lu_a and lu_b, output, 1 each, registered operands driven to the logic unit.
REQ-006 SHALL have port lu_sel, output, 3, registered opcode driven to the logic unit.
REQ-007 SHALL have port lu_out, input, 1, combinational result returned by the logic unit.
REQ-008 SHALL have ports busy (1), done (1) and pass (1) as outputs giving run status.
REQ-009 SHALL have ports fail_idx (5), err_count (6) and tt_capture (32) as outputs giving results.

Function
REQ-010 Vector index idx[4:0] SHALL map as {lu_sel, lu_a, lu_b} = idx, swept from 0 to 31.
REQ-011 Expected result per opcode SHALL be: 000 NOT a; 001 NOR; 010 AND; 011 OR; 100 XOR; 101 XNOR; 110 NAND; 111 NAND.
REQ-012 FSM SHALL have exactly the states IDLE, APPLY and DONE.
REQ-013 In IDLE or DONE, start=1 SHALL, at the same edge, load vector 0, clear all results, set busy=1 and done=0, and enter APPLY.
REQ-014 Each vector SHALL be held for exactly SETTLE_CYCLES+1 cycles, with lu_out sampled at the final edge of that window.
REQ-015 At the sampling edge, tt_capture[idx] SHALL be set to lu_out and the sample compared against the expected value.
REQ-016 On a match with idx<31, the next vector SHALL be applied at the same sampling edge.
REQ-017 On a mismatch, pass SHALL be cleared and fail_idx SHALL record idx if this is the first mismatch of the run.
REQ-018 After sampling idx=31, or on stop per REQ-025, the FSM SHALL enter DONE with busy=0, done=1, and lu_a, lu_b and lu_sel held.
REQ-019 pass SHALL be set at run start and be meaningful only while done=1.
REQ-020 A clean run SHALL assert done exactly 32*(SETTLE_CYCLES+1) cycles after the start edge.
REQ-021 start SHALL be ignored while busy=1.
REQ-022 done, pass, fail_idx, err_count and tt_capture SHALL hold their values until the next accepted start.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE and drive all outputs to 0, including mid-run.
REQ-024 After rst_n deasserts, the first start SHALL perform a complete clean run.

Configuration
REQ-025 Without LOGIC_BIST_ERRCNT_EN, the run SHALL stop at the first mismatch (DONE at that sampling edge) and err_count SHALL be tied to 0.
REQ-026 With LOGIC_BIST_ERRCNT_EN, the sweep SHALL always complete all 32 vectors and err_count SHALL count mismatches, saturating at 63.

Structure
REQ-027 Package logic_bist_pkg SHALL hold the FSM state enum, the opcode constants OP_NOT..OP_NAND2, and the constant EXP_TT = 32'h7796E813.
REQ-028 The expected model SHALL be the combinational sub-module logic_golden (inputs sel, a, b; output exp), instantiated once.

Verification
REQ-029 Correct unit, SETTLE_CYCLES=1, start pulse -> busy=1 next cycle, done=1 at cycle 64, pass=1, tt_capture=32'h7796E813, err_count=0.
REQ-030 lu_out stuck at 0, macro off -> done at cycle 2, pass=0, fail_idx=0; macro on -> done at cycle 64, err_count=17, tt_capture=0.
REQ-031 Unit with opcode 111 implemented as AND -> pass=0, fail_idx=28; with macro on, err_count=4.
REQ-032 rst_n pulsed low at cycle 20 of a run -> all outputs 0 asynchronously; the next start yields the REQ-029 results.
REQ-033 start asserted at cycle 10 of a run -> ignored, done still at 64; start while done=1 -> done=0 next cycle and a new run completes.
REQ-034 SETTLE_CYCLES=3, correct unit -> done at cycle 128, pass=1.
